n64_sdram_arbiter: RTL and testbench

N64_SDRAM_ARBITER -- requirements
Module: n64_sdram_arbiter

---
 rtl/n64_sdram_arb_pkg.sv | 26 ++
 rtl/n64_sdram_rr_picker.sv | 38 +++
 rtl/n64_sdram_arbiter.sv | 247 ++++++++++++++++++++++++
 tb/tb_n64_sdram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : n64_sdram_arb_pkg
//  Purpose  : Shared types and defaults for the N64 SDRAM arbiter: FSM state
//             encoding, requester source encoding and the default abort
//             timeout.
//  Revision : 1.0 - initial release
// ============================================================================
package n64_sdram_arb_pkg;

    localparam int c_default_timeout_cycles = 1024;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ABORT = 2'd2
    } e_state;

    typedef enum logic [1:0] {
        T_BUS = 2'd0,
        T_CPU = 2'd1,
        T_DMA = 2'd2
    } e_source;

endpackage
`default_nettype wire

// File: rtl/n64_sdram_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : n64_sdram_rr_picker
//  Purpose  : Combinational round-robin choice between the cpu and dma
//             requesters. On a tie the requester that was not granted last
//             wins.
//  Ports    : cpu_request, dma_request - live request levels
//             last_grant               - T_CPU or T_DMA, whichever won last
//             pick_valid               - at least one of the two is requesting
//             pick_source              - chosen requester (T_CPU / T_DMA)
//  Revision : 1.0 - initial release
// ============================================================================
module n64_sdram_rr_picker
    import n64_sdram_arb_pkg::*;
(
    input  logic    cpu_request,
    input  logic    dma_request,
    input  e_source last_grant,
    output logic    pick_valid,
    output e_source pick_source
);

    always_comb begin
        pick_valid  = cpu_request | dma_request;
        pick_source = T_CPU;
        if (cpu_request && dma_request) begin
            if (last_grant == T_CPU) begin
                pick_source = T_DMA;
            end else begin
                pick_source = T_CPU;
            end
        end else if (dma_request) begin
            pick_source = T_DMA;
        end
    end

endmodule
`default_nettype wire

// File: rtl/n64_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : n64_sdram_arbiter
//  Purpose  : Three-way (bus / cpu / dma) arbiter in front of a level
//             request/ack SDRAM controller. bus always wins; cpu and dma are
//             round-robin and are held off while an N64 cycle is active.
//             An access that sees no mem_ack within TIMEOUT_CYCLES wait
//             cycles is aborted: the requester gets an ack with zero data
//             and timeout_error is set (sticky until reset).
//  Ports    : clk, reset                      - single clock, sync reset
//             <r>_request/_write/_address/_wdata/_ack/_rdata, r=bus,cpu,dma
//             bus_n64_active                 - blocks cpu/dma arbitration
//             mem_request/_write/_address/_wdata/_ack/_rdata - memory side
//             timeout_error                  - sticky abort flag
//             grant_count_bus/_cpu/_dma      - only with the macro below
//  Config   : N64_SDRAM_ARB_STATS_EN adds 16-bit wrapping grant counters.
//  Revision : 1.0 - initial release
// ============================================================================
module n64_sdram_arbiter
    import n64_sdram_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_default_timeout_cycles,
    parameter int ADDR_W         = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_request,
    input  logic              bus_write,
    input  logic [31:0]       bus_address,
    input  logic [15:0]       bus_wdata,
    output logic              bus_ack,
    output logic [15:0]       bus_rdata,
    input  logic              cpu_request,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_address,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    input  logic              dma_request,
    input  logic              dma_write,
    input  logic [31:0]       dma_address,
    input  logic [15:0]       dma_wdata,
    output logic              dma_ack,
    output logic [15:0]       dma_rdata,
    input  logic              bus_n64_active,
    output logic              mem_request,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
`ifdef N64_SDRAM_ARB_STATS_EN
    output logic [15:0]       grant_count_bus,
    output logic [15:0]       grant_count_cpu,
    output logic [15:0]       grant_count_dma,
`endif
    output logic              timeout_error
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    e_state              r_state;
    e_state              w_state_next;
    e_source             r_source;
    e_source             r_last_grant;
    e_source             w_pick_source;
    e_source             w_grant_source;
    logic                w_pick_valid;
    logic                w_grant_valid;
    logic                w_timeout;
    logic                w_ack_any;
    logic                w_sel_write;
    logic [ADDR_W-1:0]   w_sel_address;
    logic [15:0]         w_sel_wdata;
    logic                r_mem_request;
    logic                r_write;
    logic [ADDR_W-1:0]   r_address;
    logic [15:0]         r_wdata;
    logic                r_timeout_error;
    logic [c_cnt_w-1:0]  r_wait_cnt;

    n64_sdram_rr_picker u_picker (
        .cpu_request (cpu_request),
        .dma_request (dma_request),
        .last_grant  (r_last_grant),
        .pick_valid  (w_pick_valid),
        .pick_source (w_pick_source)
    );

    // Upper address bits are deliberately dropped on the way to memory.
    generate
        if (ADDR_W < 32) begin : g_unused_addr
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^{bus_address[31:ADDR_W],
                                        cpu_address[31:ADDR_W],
                                        dma_address[31:ADDR_W]};
        end
    endgenerate

    // bus wins unconditionally; cpu/dma only when bus is idle and no N64 cycle
    always_comb begin
        w_grant_valid  = 1'b0;
        w_grant_source = T_BUS;
        if (bus_request) begin
            w_grant_valid  = 1'b1;
            w_grant_source = T_BUS;
        end else if (!bus_n64_active && w_pick_valid) begin
            w_grant_valid  = 1'b1;
            w_grant_source = w_pick_source;
        end
    end

    always_comb begin
        w_sel_write   = bus_write;
        w_sel_address = bus_address[ADDR_W-1:0];
        w_sel_wdata   = bus_wdata;
        case (w_grant_source)
            T_CPU: begin
                w_sel_write   = cpu_write;
                w_sel_address = cpu_address[ADDR_W-1:0];
                w_sel_wdata   = cpu_wdata;
            end
            T_DMA: begin
                w_sel_write   = dma_write;
                w_sel_address = dma_address[ADDR_W-1:0];
                w_sel_wdata   = dma_wdata;
            end
            default: ;
        endcase
    end

    // mem_ack on the last allowed wait cycle still completes normally
    assign w_timeout = (r_state == S_WAIT) && !mem_ack && (r_wait_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ack_any    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    w_ack_any    = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    w_state_next = S_ABORT;
                end
            end
            S_ABORT: begin
                w_ack_any    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase

        bus_ack   = w_ack_any && (r_source == T_BUS);
        cpu_ack   = w_ack_any && (r_source == T_CPU);
        dma_ack   = w_ack_any && (r_source == T_DMA);
        bus_rdata = (bus_ack && (r_state == S_WAIT)) ? mem_rdata : 16'h0000;
        cpu_rdata = (r_state == S_ABORT) ? 16'h0000 : mem_rdata;
        dma_rdata = (r_state == S_ABORT) ? 16'h0000 : mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_request   <= 1'b0;
            r_timeout_error <= 1'b0;
            r_wait_cnt      <= '0;
            r_last_grant    <= T_DMA;
            r_source        <= T_BUS;
            r_write         <= 1'b0;
            r_address       <= '0;
            r_wdata         <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_source      <= w_grant_source;
                        r_write       <= w_sel_write;
                        r_address     <= w_sel_address;
                        r_wdata       <= w_sel_wdata;
                        r_mem_request <= 1'b1;
                        r_wait_cnt    <= '0;
                        if (w_grant_source != T_BUS) begin
                            r_last_grant <= w_grant_source;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        r_mem_request <= 1'b0;
                    end else if (w_timeout) begin
                        r_mem_request   <= 1'b0;
                        r_timeout_error <= 1'b1;
                    end else if (r_wait_cnt != c_cnt_last) begin
                        r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef N64_SDRAM_ARB_STATS_EN
    logic [15:0] r_grant_count_bus;
    logic [15:0] r_grant_count_cpu;
    logic [15:0] r_grant_count_dma;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant_count_bus <= 16'h0000;
            r_grant_count_cpu <= 16'h0000;
            r_grant_count_dma <= 16'h0000;
        end else if ((r_state == S_IDLE) && w_grant_valid) begin
            case (w_grant_source)
                T_BUS:   r_grant_count_bus <= r_grant_count_bus + 16'd1;
                T_CPU:   r_grant_count_cpu <= r_grant_count_cpu + 16'd1;
                default: r_grant_count_dma <= r_grant_count_dma + 16'd1;
            endcase
        end
    end

    assign grant_count_bus = r_grant_count_bus;
    assign grant_count_cpu = r_grant_count_cpu;
    assign grant_count_dma = r_grant_count_dma;
`endif

    assign mem_request   = r_mem_request;
    assign mem_write     = r_write;
    assign mem_address   = r_address;
    assign mem_wdata     = r_wdata;
    assign timeout_error = r_timeout_error;

endmodule
`default_nettype wire

// File: tb/tb_n64_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_n64_sdram_arbiter
//  Purpose  : Self-checking bench for n64_sdram_arbiter. Directed requests
//             push expected (source, rdata) pairs into a scoreboard; a
//             monitor pops and compares on every ack pulse. A small memory
//             model answers mem_request after a programmable latency.
//             Grant counters are checked when N64_SDRAM_ARB_STATS_EN is set.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_n64_sdram_arbiter;

    localparam int          c_timeout  = 16;
    localparam int          c_addr_w   = 26;
    localparam logic [31:0] c_mask     = 32'h03FF_FFFF;
    localparam logic [31:0] c_bus_addr = 32'hFC00_1234;
    localparam logic [31:0] c_cpu_addr = 32'h0123_4566;
    localparam logic [31:0] c_dma_addr = 32'h0345_6788;

    logic clk = 1'b0;
    logic reset;
    logic bus_request, cpu_request, dma_request, bus_n64_active;
    logic bus_ack, cpu_ack, dma_ack;
    logic [15:0] bus_rdata, cpu_rdata, dma_rdata;
    logic mem_request, mem_write, mem_ack;
    logic [c_addr_w-1:0] mem_address;
    logic [15:0] mem_wdata, mem_rdata;
    logic timeout_error;
`ifdef N64_SDRAM_ARB_STATS_EN
    logic [15:0] grant_count_bus, grant_count_cpu, grant_count_dma;
`endif

    typedef struct {
        int          src;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    int          left[3];
    int          mem_lat;
    int          mem_cnt;
    logic [15:0] mem_val;

    always #5 clk = ~clk;
    assign mem_rdata = mem_val;

    n64_sdram_arbiter #(
        .TIMEOUT_CYCLES (c_timeout),
        .ADDR_W         (c_addr_w)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus_request    (bus_request),
        .bus_write      (1'b1),
        .bus_address    (c_bus_addr),
        .bus_wdata      (16'h1111),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata),
        .cpu_request    (cpu_request),
        .cpu_write      (1'b1),
        .cpu_address    (c_cpu_addr),
        .cpu_wdata      (16'hBEEF),
        .cpu_ack        (cpu_ack),
        .cpu_rdata      (cpu_rdata),
        .dma_request    (dma_request),
        .dma_write      (1'b0),
        .dma_address    (c_dma_addr),
        .dma_wdata      (16'h5555),
        .dma_ack        (dma_ack),
        .dma_rdata      (dma_rdata),
        .bus_n64_active (bus_n64_active),
        .mem_request    (mem_request),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
`ifdef N64_SDRAM_ARB_STATS_EN
        .grant_count_bus(grant_count_bus),
        .grant_count_cpu(grant_count_cpu),
        .grant_count_dma(grant_count_dma),
`endif
        .timeout_error  (timeout_error)
    );

    function automatic logic [31:0] exp_addr(input int r);
        case (r)
            0:       return c_bus_addr & c_mask;
            1:       return c_cpu_addr & c_mask;
            default: return c_dma_addr & c_mask;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input int r);
        case (r)
            0:       return 32'h1111;
            1:       return 32'hBEEF;
            default: return 32'h5555;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_req(input int r, input logic v);
        case (r)
            0:       bus_request = v;
            1:       cpu_request = v;
            default: dma_request = v;
        endcase
    endtask

    task automatic push(input int s, input logic [15:0] d);
        exp_t e;
        e.src   = s;
        e.rdata = d;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((sb.size() != 0 || bus_request || cpu_request || dma_request) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || bus_request || cpu_request || dma_request) begin
            total++;
            $display("FAIL %s: drain timeout, %0d acks still expected", name, sb.size());
            sb.delete();
            bus_request = 1'b0;
            cpu_request = 1'b0;
            dma_request = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic wait_mem_request(input string name);
        for (int n = 0; n < 10 && !mem_request; n++) @(negedge clk);
        if (!mem_request) begin
            total++;
            $display("FAIL %s: mem_request never rose, got 0 expected 1", name);
        end
    endtask

    // memory model: ack after mem_lat cycles of mem_request
    initial begin
        mem_ack = 1'b0;
        mem_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_request && !mem_ack) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) mem_ack = 1'b1;
            end else begin
                mem_ack = 1'b0;
                mem_cnt = 0;
            end
        end
    end

    // monitor: every ack pops one scoreboard entry
    logic [2:0]  mon_acks;
    logic [15:0] mon_rd;
    exp_t        mon_e;
    initial begin
        forever begin
            @(negedge clk);
            mon_acks = {dma_ack, cpu_ack, bus_ack};
            if (mon_acks != 3'b000) begin
                check("ack_onehot", $countones(mon_acks), 1);
                for (int r = 0; r < 3; r++) begin
                    if (mon_acks[r]) begin
                        if (sb.size() == 0) begin
                            total++;
                            $display("FAIL unexpected_ack: got ack on source %0d, expected none", r);
                        end else begin
                            mon_e  = sb.pop_front();
                            mon_rd = (r == 0) ? bus_rdata : (r == 1) ? cpu_rdata : dma_rdata;
                            check("ack_source", r, mon_e.src);
                            check("ack_rdata", {16'h0, mon_rd}, {16'h0, mon_e.rdata});
                            check("mem_address", {6'h0, mem_address}, exp_addr(r));
                            check("mem_write", {31'h0, mem_write}, (r == 2) ? 32'h0 : 32'h1);
                            check("mem_wdata", {16'h0, mem_wdata}, exp_wdata(r));
                        end
                        left[r]--;
                        if (left[r] <= 0) set_req(r, 1'b0);
                    end
                end
            end
            if (!bus_ack) check("bus_rdata_idle", {16'h0, bus_rdata}, 32'h0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    int hi;
    initial begin
        reset = 1'b1;
        bus_request = 1'b0;
        cpu_request = 1'b0;
        dma_request = 1'b0;
        bus_n64_active = 1'b0;
        mem_lat = 1000;
        mem_val = 16'h1234;
        left = '{0, 0, 0};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_mem_request", {31'h0, mem_request}, 32'h0);
        check("reset_timeout_error", {31'h0, timeout_error}, 32'h0);
        check("reset_acks", {29'h0, dma_ack, cpu_ack, bus_ack}, 32'h0);

        // all three at once: bus first, then cpu wins the first tie
        @(posedge clk); #1;
        mem_lat = 4; mem_val = 16'h1234;
        push(0, 16'h1234); push(1, 16'h1234); push(2, 16'h1234);
        left = '{1, 1, 1};
        bus_request = 1'b1; cpu_request = 1'b1; dma_request = 1'b1;
        wait_drain(200, "three_way");

        // cpu/dma held: alternation
        @(posedge clk); #1;
        mem_lat = 2; mem_val = 16'hA5A5;
        push(1, 16'hA5A5); push(2, 16'hA5A5); push(1, 16'hA5A5); push(2, 16'hA5A5);
        left = '{0, 2, 2};
        cpu_request = 1'b1; dma_request = 1'b1;
        wait_drain(200, "round_robin");

        // N64 cycle blocks cpu
        @(posedge clk); #1;
        mem_lat = 1; mem_val = 16'h0F0F;
        bus_n64_active = 1'b1;
        push(1, 16'h0F0F);
        left = '{0, 1, 0};
        cpu_request = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("n64_block", {31'h0, mem_request}, 32'h0);
        end
        @(posedge clk); #1 bus_n64_active = 1'b0;
        @(negedge clk);
        check("n64_release_same_cycle", {31'h0, mem_request}, 32'h0);
        @(negedge clk);
        check("n64_release_grant", {31'h0, mem_request}, 32'h1);
        wait_drain(100, "n64_block");

        // no mem_ack: abort after 16 wait cycles, dma acked with zero data
        @(posedge clk); #1;
        mem_lat = 1000; mem_val = 16'hDEAD;
        push(2, 16'h0000);
        left = '{0, 0, 1};
        dma_request = 1'b1;
        wait_mem_request("timeout_start");
        hi = 0;
        while (mem_request && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        check("timeout_wait_cycles", hi, c_timeout);
        check("timeout_error_set", {31'h0, timeout_error}, 32'h1);
        wait_drain(50, "timeout");

        // reset in the middle of an access: no ack, flags cleared
        @(posedge clk); #1;
        left = '{0, 1, 0};
        cpu_request = 1'b1;
        wait_mem_request("reset_mid_start");
        repeat (3) @(negedge clk);
        check("timeout_sticky", {31'h0, timeout_error}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        cpu_request = 1'b0;
        left = '{0, 0, 0};
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_mem_request", {31'h0, mem_request}, 32'h0);
        check("reset_mid_acks", {29'h0, dma_ack, cpu_ack, bus_ack}, 32'h0);
        check("reset_mid_timeout_error", {31'h0, timeout_error}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);

        // 3 bus, 2 cpu, 5 dma grants
        @(posedge clk); #1;
        mem_lat = 1; mem_val = 16'h3C3C;
        for (int i = 0; i < 3; i++) push(0, 16'h3C3C);
        push(1, 16'h3C3C); push(2, 16'h3C3C); push(1, 16'h3C3C);
        for (int i = 0; i < 4; i++) push(2, 16'h3C3C);
        left = '{3, 2, 5};
        bus_request = 1'b1; cpu_request = 1'b1; dma_request = 1'b1;
        wait_drain(400, "stats_traffic");
`ifdef N64_SDRAM_ARB_STATS_EN
        check("grant_count_bus", {16'h0, grant_count_bus}, 32'd3);
        check("grant_count_cpu", {16'h0, grant_count_cpu}, 32'd2);
        check("grant_count_dma", {16'h0, grant_count_dma}, 32'd5);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
